// File: rtl/unidade_controle_exp6_pkg.sv
// State codes for the memory-game control unit; shared with the datapath
// debug decoder and the benches.
package unidade_controle_exp6_pkg;

  localparam int ESTADO_W = 5;

  typedef enum logic [ESTADO_W-1:0] {
    ST_INICIAL            = 5'h00,
    ST_PREPARACAO         = 5'h01,
    ST_ESPERA_JOGADA      = 5'h03,
    ST_REGISTRA           = 5'h04,
    ST_COMPARACAO         = 5'h05,
    ST_PROXIMO            = 5'h06,
    ST_INCREMENTA_ESCRITA = 5'h07,
    ST_ESPERA_ESCRITA     = 5'h08,
    ST_REGISTRA_ESCRITA   = 5'h09,
    ST_ESCREVE            = 5'h0A,
    ST_PROXIMA_RODADA     = 5'h0B,
    ST_FIM_ACERTOU        = 5'h1A,
    ST_FIM_TIMEOUT        = 5'h1D,
    ST_FIM_ERROU          = 5'h1E
  } estado_t;

endpackage

// File: rtl/unidade_controle_exp6.sv
// Moore control FSM for the memory game: sequences counters, play register,
// RAM write and timer, and reports win / loss / timeout.
module unidade_controle_exp6
  import unidade_controle_exp6_pkg::*;
#(
  parameter bit TIMEOUT_EN = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                fimE,
  input  logic                fimRod,
  input  logic                fimT,
  input  logic                igual,
  input  logic                enderecoIgualRodada,
  input  logic                jogada_feita,
  output logic                zeraE,
  output logic                contaE,
  output logic                zeraRod,
  output logic                contaRod,
  output logic                zeraT,
  output logic                contaT,
  output logic                zeraR,
  output logic                registraR,
  output logic                we,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                timeout,
  output logic [ESTADO_W-1:0] db_estado
);

  estado_t r_estado;
  estado_t w_proximo;
  logic    w_unused_fim_e;

  // fimE is exported for debug only and never steers the sequence.
  assign w_unused_fim_e = fimE;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= ST_INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  always_comb begin
    w_proximo = ST_INICIAL;
    case (r_estado)
      ST_INICIAL:            w_proximo = jogar ? ST_PREPARACAO : ST_INICIAL;
      ST_PREPARACAO:         w_proximo = ST_ESPERA_JOGADA;
      ST_ESPERA_JOGADA: begin
        if (jogada_feita)              w_proximo = ST_REGISTRA;
        else if (fimT && TIMEOUT_EN)   w_proximo = ST_FIM_TIMEOUT;
        else                           w_proximo = ST_ESPERA_JOGADA;
      end
      ST_REGISTRA:           w_proximo = ST_COMPARACAO;
      ST_COMPARACAO: begin
        if (!igual)                    w_proximo = ST_FIM_ERROU;
        else if (enderecoIgualRodada)  w_proximo = fimRod ? ST_FIM_ACERTOU
                                                          : ST_INCREMENTA_ESCRITA;
        else                           w_proximo = ST_PROXIMO;
      end
      ST_PROXIMO:            w_proximo = ST_ESPERA_JOGADA;
      ST_INCREMENTA_ESCRITA: w_proximo = ST_ESPERA_ESCRITA;
      ST_ESPERA_ESCRITA: begin
        if (jogada_feita)              w_proximo = ST_REGISTRA_ESCRITA;
        else if (fimT && TIMEOUT_EN)   w_proximo = ST_FIM_TIMEOUT;
        else                           w_proximo = ST_ESPERA_ESCRITA;
      end
      ST_REGISTRA_ESCRITA:   w_proximo = ST_ESCREVE;
      ST_ESCREVE:            w_proximo = ST_PROXIMA_RODADA;
      ST_PROXIMA_RODADA:     w_proximo = ST_ESPERA_JOGADA;
      ST_FIM_ACERTOU:        w_proximo = jogar ? ST_PREPARACAO : ST_FIM_ACERTOU;
      ST_FIM_ERROU:          w_proximo = jogar ? ST_PREPARACAO : ST_FIM_ERROU;
      ST_FIM_TIMEOUT:        w_proximo = jogar ? ST_PREPARACAO : ST_FIM_TIMEOUT;
      default:               w_proximo = ST_INICIAL;
    endcase
  end

  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraRod   = 1'b0;
    contaRod  = 1'b0;
    zeraT     = 1'b0;
    contaT    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    we        = 1'b0;
    pronto    = 1'b0;
    ganhou    = 1'b0;
    perdeu    = 1'b0;
    timeout   = 1'b0;
    case (r_estado)
      ST_PREPARACAO: begin
        zeraE   = 1'b1;
        zeraRod = 1'b1;
        zeraR   = 1'b1;
        zeraT   = 1'b1;
      end
      ST_ESPERA_JOGADA, ST_ESPERA_ESCRITA: contaT = 1'b1;
      ST_REGISTRA, ST_REGISTRA_ESCRITA: begin
        registraR = 1'b1;
        zeraT     = 1'b1;
      end
      ST_PROXIMO, ST_INCREMENTA_ESCRITA: begin
        contaE = 1'b1;
        zeraT  = 1'b1;
      end
      // Register was loaded last cycle, so RAM data is already stable here.
      ST_ESCREVE: we = 1'b1;
      ST_PROXIMA_RODADA: begin
        contaRod = 1'b1;
        zeraE    = 1'b1;
        zeraT    = 1'b1;
      end
      ST_FIM_ACERTOU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      ST_FIM_ERROU: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      ST_FIM_TIMEOUT: begin
        pronto  = 1'b1;
        perdeu  = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = r_estado;

endmodule

// File: tb/tb_unidade_controle_exp6.sv
// Scoreboard bench: a driver feeds directed and random inputs to two DUTs
// (timeout enabled / disabled) and queues expected outputs; a monitor checks.
module tb_unidade_controle_exp6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, jogar, fimE, fimRod, fimT, igual, enderecoIgualRodada, jogada_feita;
  logic [12:0] o_vec [2];
  logic [4:0]  o_est [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      unidade_controle_exp6 #(.TIMEOUT_EN(gi == 1)) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .fimE(fimE),
        .fimRod(fimRod), .fimT(fimT), .igual(igual),
        .enderecoIgualRodada(enderecoIgualRodada), .jogada_feita(jogada_feita),
        .zeraE(o_vec[gi][12]), .contaE(o_vec[gi][11]),
        .zeraRod(o_vec[gi][10]), .contaRod(o_vec[gi][9]),
        .zeraT(o_vec[gi][8]), .contaT(o_vec[gi][7]),
        .zeraR(o_vec[gi][6]), .registraR(o_vec[gi][5]),
        .we(o_vec[gi][4]), .pronto(o_vec[gi][3]), .ganhou(o_vec[gi][2]),
        .perdeu(o_vec[gi][1]), .timeout(o_vec[gi][0]),
        .db_estado(o_est[gi])
      );
    end
  endgenerate

  // Output bit masks, same order as o_vec.
  localparam logic [12:0] ZE = 13'h1000, CE = 13'h0800, ZROD = 13'h0400,
                          CROD = 13'h0200, ZT = 13'h0100, CT = 13'h0080,
                          ZR = 13'h0040, RR = 13'h0020, WE = 13'h0010,
                          PR = 13'h0008, GA = 13'h0004, PE = 13'h0002,
                          TO = 13'h0001;

  typedef struct packed {
    logic rst, jog, jf, ft, ig, eir, fr, fe;
  } stim_t;

  typedef struct packed {
    logic [4:0]  s1, s0;
    logic [12:0] o1, o0;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [4:0] m_s [2];

  // Reference game rules: what the player's action in each phase leads to.
  function automatic logic [4:0] ref_next(input logic [4:0] s, input bit ten, input stim_t st);
    if (st.rst) return 5'h00;
    case (s)
      5'h00: return st.jog ? 5'h01 : 5'h00;
      5'h01: return 5'h03;
      5'h03, 5'h08: begin
        if (st.jf) return (s == 5'h03) ? 5'h04 : 5'h09;
        if (st.ft && ten) return 5'h1D;
        return s;
      end
      5'h04: return 5'h05;
      5'h05: begin
        if (!st.ig) return 5'h1E;
        if (!st.eir) return 5'h06;
        return st.fr ? 5'h1A : 5'h07;
      end
      5'h06: return 5'h03;
      5'h07: return 5'h08;
      5'h09: return 5'h0A;
      5'h0A: return 5'h0B;
      5'h0B: return 5'h03;
      5'h1A, 5'h1D, 5'h1E: return st.jog ? 5'h01 : s;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic [12:0] ref_out(input logic [4:0] s);
    case (s)
      5'h01: return ZE | ZROD | ZR | ZT;
      5'h03, 5'h08: return CT;
      5'h04, 5'h09: return RR | ZT;
      5'h06, 5'h07: return CE | ZT;
      5'h0A: return WE;
      5'h0B: return CROD | ZE | ZT;
      5'h1A: return PR | GA;
      5'h1E: return PR | PE;
      5'h1D: return PR | PE | TO;
      default: return 13'h0000;
    endcase
  endfunction

  task automatic drive(input stim_t st);
    exp_t e;
    @(negedge clock);
    reset = st.rst; jogar = st.jog; jogada_feita = st.jf; fimT = st.ft;
    igual = st.ig; enderecoIgualRodada = st.eir; fimRod = st.fr; fimE = st.fe;
    for (int i = 0; i < 2; i++) m_s[i] = ref_next(m_s[i], i == 1, st);
    e.s1 = m_s[1]; e.s0 = m_s[0];
    e.o1 = ref_out(m_s[1]); e.o0 = ref_out(m_s[0]);
    exp_q.push_back(e);
  endtask

  // Directed step: rst, jogar, jogada_feita, fimT, igual, enderecoIgualRodada, fimRod.
  task automatic step(input logic r, input logic j, input logic jf, input logic ft,
                      input logic ig, input logic eir, input logic fr);
    stim_t st;
    st = '{rst: r, jog: j, jf: jf, ft: ft, ig: ig, eir: eir, fr: fr, fe: 1'b0};
    drive(st);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total += 4;
        if (o_est[1] !== e.s1) begin
          bad++; $display("FAIL est_ten1 t=%0t got=%h exp=%h", $time, o_est[1], e.s1);
        end
        if (o_vec[1] !== e.o1) begin
          bad++; $display("FAIL out_ten1 t=%0t st=%h got=%h exp=%h", $time, e.s1, o_vec[1], e.o1);
        end
        if (o_est[0] !== e.s0) begin
          bad++; $display("FAIL est_ten0 t=%0t got=%h exp=%h", $time, o_est[0], e.s0);
        end
        if (o_vec[0] !== e.o0) begin
          bad++; $display("FAIL out_ten0 t=%0t st=%h got=%h exp=%h", $time, e.s0, o_vec[0], e.o0);
        end
        $display("chk t=%0t est1=%h out1=%h est0=%h out0=%h", $time, o_est[1], o_vec[1], o_est[0], o_vec[0]);
      end
    end
  end

  initial begin : driver
    stim_t st;
    reset = 1'b1; jogar = 1'b0; fimE = 1'b0; fimRod = 1'b0; fimT = 1'b0;
    igual = 1'b0; enderecoIgualRodada = 1'b0; jogada_feita = 1'b0;
    m_s[0] = 5'h00; m_s[1] = 5'h00;

    // Reach espera_escrita, reset there, restart with jogar held.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 1, 0);
    idle(1);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    // Full round 0: compare, then write path.
    step(0, 0, 1, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 1, 0);
    idle(1);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(3);
    // Wrong play, then restart.
    step(0, 0, 1, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(1);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    // Timeout (only the enabled instance leaves espera_jogada).
    step(0, 0, 0, 1, 0, 0, 0);
    idle(1);
    step(0, 1, 0, 0, 0, 0, 0);
    // Play and timer expiry together, then final-round win held 10 cycles.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 1, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 1, 1);
    idle(10);
    step(0, 1, 0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      st.rst = ($urandom_range(0, 49) == 0);
      st.jog = ($urandom_range(0, 7) == 0);
      st.jf  = ($urandom_range(0, 3) == 0);
      st.ft  = ($urandom_range(0, 7) == 0);
      st.ig  = ($urandom_range(0, 3) != 0);
      st.eir = $urandom_range(0, 1) == 1;
      st.fr  = ($urandom_range(0, 3) == 0);
      st.fe  = $urandom_range(0, 1) == 1;
      drive(st);
    end

    repeat (3) @(negedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
